addsub_flag_stage: RTL and testbench

//  Registered output stage placed directly downstream of the 32-bit adder/subtractor.

---
 rtl/addsub_flag_stage.sv | 131 +++++++++++++
 tb/tb_addsub_flag_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_flag_stage.sv
// Registered flag stage behind the 32-bit adder/subtractor: derives C/V/Z/N per beat,
// buffers beats in a 2-entry skid buffer and counts overflow beats with saturation.
module addsub_flag_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ss,
   input  logic             cc,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_count
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
      logic             z;
      logic             n;
   } beat_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   beat_t            out_q, out_d;
   beat_t            skid_q, skid_d;
   logic             in_ready_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   beat_t in_beat;
   logic  y_msb;
   logic  accept;
   logic  emit;

   // For subtract the adder sees ~B, so the effective B sign is inverted.
   always_comb begin
      y_msb       = b_msb ^ sub;
      in_beat.res = ss;
      in_beat.c   = cc;
      in_beat.v   = (a_msb == y_msb) & (ss[WIDTH-1] != a_msb);
      in_beat.z   = ~|ss;
      in_beat.n   = ss[WIDTH-1];
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready_q;
   assign emit      = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               out_d   = in_beat;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && !emit) begin
               skid_d  = in_beat;
               state_d = TWO;
            end else if (emit && !accept) begin
               state_d = EMPTY;
            end else if (accept && emit) begin
               out_d   = in_beat;
            end
         end
         TWO: begin
            if (emit) begin
               out_d   = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Clear wins over a simultaneous overflow accept; the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = '0;
      end else if (accept && in_beat.v && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != TWO);
         cnt_q      <= cnt_d;
      end
   end

   assign result    = out_q.res;
   assign flag_c    = out_q.c;
   assign flag_v    = out_q.v;
   assign flag_z    = out_q.z;
   assign flag_n    = out_q.n;
   assign ovf_count = cnt_q;

endmodule

// File: tb/tb_addsub_flag_stage.sv
// Directed bench for addsub_flag_stage: flags, skid backpressure ordering,
// counter saturation/clear and asynchronous reset.
module tb_addsub_flag_stage;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [31:0] ss;
   logic        cc;
   logic        aMsb;
   logic        bMsb;
   logic        sub;
   logic        outValid;
   logic        outReady;
   logic [31:0] result;
   logic        flagC;
   logic        flagV;
   logic        flagZ;
   logic        flagN;
   logic [7:0]  ovfCount;
   logic        clrCount;

   int nCompared;
   int nMismatched;

   addsub_flag_stage #(.WIDTH(32), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .ss        (ss),
      .cc        (cc),
      .a_msb     (aMsb),
      .b_msb     (bMsb),
      .sub       (sub),
      .out_valid (outValid),
      .out_ready (outReady),
      .result    (result),
      .flag_c    (flagC),
      .flag_v    (flagV),
      .flag_z    (flagZ),
      .flag_n    (flagN),
      .ovf_count (ovfCount),
      .clr_count (clrCount)
   );

   // 10 ns clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one beat's payload and raises in_valid
   task automatic applyStimulus(input logic [31:0] s, input logic c, input logic a,
                                input logic b, input logic sb);
      ss      = s;
      cc      = c;
      aMsb    = a;
      bMsb    = b;
      sub     = sb;
      inValid = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 ns past the next rising edge, where inputs are driven and outputs sampled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkFlags(input string tag, input logic [31:0] r, input logic c,
                             input logic v, input logic z, input logic n);
      checkOutput({tag, "_valid"}, 64'(outValid), 64'd1);
      checkOutput({tag, "_result"}, 64'(result), 64'(r));
      checkOutput({tag, "_C"}, 64'(flagC), 64'(c));
      checkOutput({tag, "_V"}, 64'(flagV), 64'(v));
      checkOutput({tag, "_Z"}, 64'(flagZ), 64'(z));
      checkOutput({tag, "_N"}, 64'(flagN), 64'(n));
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst_n    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      clrCount = 1'b0;
      ss       = '0;
      cc       = 1'b0;
      aMsb     = 1'b0;
      bMsb     = 1'b0;
      sub      = 1'b0;

      tick();
      tick();
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("rst_ovf", 64'(ovfCount), 64'd0);
      checkOutput("rst_result", 64'(result), 64'd0);
      checkOutput("rst_flags", 64'({flagC, flagV, flagZ, flagN}), 64'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] subtract 39-136");
      applyStimulus(32'hFFFF_FF9F, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      inValid = 1'b0;
      checkFlags("sub39_136", 32'hFFFF_FF9F, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("drain_empty", 64'(outValid), 64'd0);

      $display("[TB] add 0+FFFFFFFF");
      applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      inValid = 1'b0;
      checkFlags("add0_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("add0_ovf", 64'(ovfCount), 64'd0);
      tick();

      $display("[TB] add 7FFFFFFF+1");
      applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      inValid = 1'b0;
      checkFlags("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("add_ovf_cnt", 64'(ovfCount), 64'd1);
      tick();

      $display("[TB] subtract 5-5");
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      inValid = 1'b0;
      checkFlags("sub5_5", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("sub5_5_cnt", 64'(ovfCount), 64'd1);
      tick();

      $display("[TB] backpressure");
      outReady = 1'b0;
      applyStimulus(32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("bp1_result", 64'(result), 64'd1);
      checkOutput("bp1_in_ready", 64'(inReady), 64'd1);
      applyStimulus(32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("bp2_in_ready", 64'(inReady), 64'd0);
      checkOutput("bp2_result", 64'(result), 64'd1);
      checkOutput("bp2_valid", 64'(outValid), 64'd1);
      applyStimulus(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("bp3_stall_ready", 64'(inReady), 64'd0);
      checkOutput("bp3_stall_result", 64'(result), 64'd1);
      outReady = 1'b1;
      tick();
      checkOutput("rel_beat2", 64'(result), 64'd2);
      checkOutput("rel_beat2_valid", 64'(outValid), 64'd1);
      checkOutput("rel_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      checkOutput("rel_beat3", 64'(result), 64'd3);
      checkOutput("rel_beat3_valid", 64'(outValid), 64'd1);
      tick();
      checkOutput("rel_empty", 64'(outValid), 64'd0);
      checkOutput("bp_cnt", 64'(ovfCount), 64'd1);

      $display("[TB] saturation");
      applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 100) checkOutput("sat_mid", 64'(ovfCount), 64'd102);
      end
      checkOutput("sat_255", 64'(ovfCount), 64'd255);
      checkOutput("sat_in_ready", 64'(inReady), 64'd1);
      clrCount = 1'b1;
      tick();
      clrCount = 1'b0;
      inValid  = 1'b0;
      checkOutput("clr_priority", 64'(ovfCount), 64'd0);
      checkOutput("clr_beat_v", 64'(flagV), 64'd1);
      tick();
      checkOutput("clr_hold", 64'(ovfCount), 64'd0);
      applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      inValid = 1'b0;
      checkOutput("after_clr", 64'(ovfCount), 64'd1);
      tick();

      $display("[TB] reset mid-stream");
      outReady = 1'b0;
      applyStimulus(32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      inValid = 1'b0;
      checkOutput("pre_rst_ready", 64'(inReady), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 64'(outValid), 64'd0);
      checkOutput("async_rst_ready", 64'(inReady), 64'd1);
      checkOutput("async_rst_ovf", 64'(ovfCount), 64'd0);
      checkOutput("async_rst_result", 64'(result), 64'd0);
      tick();
      rst_n    = 1'b1;
      outReady = 1'b1;
      tick();
      checkOutput("post_rst_dropped", 64'(outValid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
